// File: rtl/osd_trace_sample_buffer.sv
// Trace sample FIFO with drop accounting: when the FIFO is full, dropped samples are
// counted and later reported in-band as a single overflow record.
module osd_trace_sample_buffer #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sample_data,
   input  logic             sample_valid,
   output logic [WIDTH-1:0] trace_data,
   output logic             trace_overflow,
   output logic             trace_valid,
   input  logic             trace_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic {ST_NORMAL, ST_PENDING} state_t;

   logic [WIDTH:0]   r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_cnt;
   state_t           r_state, w_state_nxt;
   logic [9:0]       r_ovf_cnt, w_ovf_cnt_nxt;
   logic             w_push, w_pop, w_space;
   logic [WIDTH:0]   w_wr_entry, w_head;
   logic [WIDTH-1:0] w_ovf_payload;

   assign trace_valid = (r_cnt != '0);
   assign w_pop       = trace_valid & trace_ready;
   // A pop frees a slot in the same edge, so a full FIFO can still accept one push.
   assign w_space     = (r_cnt < CNT_FULL) | w_pop;

   always_comb begin
      w_ovf_payload      = '0;
      w_ovf_payload[9:0] = r_ovf_cnt;
   end

   always_comb begin
      w_push        = 1'b0;
      w_wr_entry    = {1'b0, sample_data};
      w_state_nxt   = r_state;
      w_ovf_cnt_nxt = r_ovf_cnt;
      case (r_state)
         ST_NORMAL: begin
            if (sample_valid) begin
               if (w_space) begin
                  w_push = 1'b1;
               end else begin
                  w_ovf_cnt_nxt = 10'd1;
                  w_state_nxt   = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (w_space) begin
               // Overflow record wins the slot; a coincident sample starts a new drop run.
               w_push     = 1'b1;
               w_wr_entry = {1'b1, w_ovf_payload};
               if (sample_valid) begin
                  w_ovf_cnt_nxt = 10'd1;
               end else begin
                  w_ovf_cnt_nxt = 10'd0;
                  w_state_nxt   = ST_NORMAL;
               end
            end else if (sample_valid && (r_ovf_cnt != 10'h3FF)) begin
               w_ovf_cnt_nxt = r_ovf_cnt + 10'd1;
            end
         end
         default: w_state_nxt = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_NORMAL;
         r_ovf_cnt <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ovf_cnt <= w_ovf_cnt_nxt;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_wr_entry;
   end

   assign w_head         = r_mem[r_rptr];
   assign trace_data     = trace_valid ? w_head[WIDTH-1:0] : '0;
   assign trace_overflow = trace_valid & w_head[WIDTH];

endmodule

// File: tb/tb_osd_trace_sample_buffer.sv
// Bench for osd_trace_sample_buffer: queue-based reference model checked every cycle,
// plus directed scenarios whose delivered streams are compared to literal lists.
module tb_osd_trace_sample_buffer;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] sample_data;
   logic             sample_valid;
   logic [WIDTH-1:0] trace_data;
   logic             trace_overflow;
   logic             trace_valid;
   logic             trace_ready;

   osd_trace_sample_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .trace_data(trace_data), .trace_overflow(trace_overflow),
      .trace_valid(trace_valid), .trace_ready(trace_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the FIFO as a queue, drop run as a flag plus count.
   logic [WIDTH:0] m_q[$];
   bit             m_pend;
   int             m_cnt;
   bit             m_pop, m_space;
   logic [WIDTH:0] m_head;
   logic [WIDTH:0] dut_log[$];
   logic [WIDTH:0] exp_q[$];

   always @(negedge rst_n) begin
      m_q.delete(); m_pend = 0; m_cnt = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_q.delete(); m_pend = 0; m_cnt = 0;
      end else begin
         m_pop   = (m_q.size() != 0) && trace_ready;
         m_space = (m_q.size() < DEPTH) || m_pop;
         if (m_pop) void'(m_q.pop_front());
         if (!m_pend) begin
            if (sample_valid) begin
               if (m_space) m_q.push_back({1'b0, sample_data});
               else begin m_pend = 1; m_cnt = 1; end
            end
         end else if (m_space) begin
            m_q.push_back({1'b1, 16'(m_cnt)});
            if (sample_valid) m_cnt = 1;
            else begin m_cnt = 0; m_pend = 0; end
         end else if (sample_valid) begin
            m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         m_head = (m_q.size() != 0) ? m_q[0] : '0;
         chk("valid", 32'(trace_valid), 32'(m_q.size() != 0));
         chk("data",  32'(trace_data),  32'(m_head[WIDTH-1:0]));
         chk("ovf",   32'(trace_overflow), 32'(m_head[WIDTH]));
         if (trace_valid && trace_ready) dut_log.push_back({trace_overflow, trace_data});
      end
   end

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
      sample_valid = v; sample_data = d; trace_ready = r;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      repeat (DEPTH + 4) drive(1'b0, '0, 1'b1);
   endtask

   task automatic expect_log(input string nm);
      chk({nm, "_len"}, 32'(dut_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < dut_log.size(); i++)
         chk($sformatf("%s_%0d", nm, i), 32'(dut_log[i]), 32'(exp_q[i]));
      dut_log.delete(); exp_q.delete();
   endtask

   initial begin
      int thr;
      sample_valid = 0; sample_data = '0; trace_ready = 0;
      rst_n = 1;
      #1 rst_n = 0;
      #2;
      chk("rst_valid", 32'(trace_valid), 32'd0);
      chk("rst_data",  32'(trace_data),  32'd0);
      chk("rst_ovf",   32'(trace_overflow), 32'd0);
      @(posedge clk); #1 rst_n = 1;

      // in-order delivery and one-cycle latency
      dut_log.delete();
      drive(1'b1, 16'h1111, 1'b1);
      chk("lat_valid", 32'(trace_valid), 32'd1);
      chk("lat_data",  32'(trace_data),  32'h1111);
      drive(1'b1, 16'h2222, 1'b1);
      chk("ord_data2", 32'(trace_data), 32'h2222);
      drive(1'b1, 16'h3333, 1'b1);
      chk("ord_data3", 32'(trace_data), 32'h3333);
      drive(1'b0, '0, 1'b1);
      chk("ord_empty", 32'(trace_valid), 32'd0);
      exp_q = '{17'h01111, 17'h02222, 17'h03333};
      expect_log("order");

      // 7 samples into a stalled FIFO: 4 kept, 3 dropped
      for (int i = 0; i < 7; i++) drive(1'b1, 16'hA000 + 16'(i), 1'b0);
      drain();
      exp_q = '{17'h0A000, 17'h0A001, 17'h0A002, 17'h0A003, 17'h10003};
      expect_log("ovf3");

      // drop count saturates
      for (int i = 0; i < 4; i++) drive(1'b1, 16'hB000 + 16'(i), 1'b0);
      for (int i = 0; i < 1100; i++) drive(1'b1, 16'($urandom), 1'b0);
      drain();
      exp_q = '{17'h0B000, 17'h0B001, 17'h0B002, 17'h0B003, 17'h103FF};
      expect_log("sat");

      // full FIFO, pop and sample together: sample accepted, no overflow record
      for (int i = 0; i < 4; i++) drive(1'b1, 16'hC000 + 16'(i), 1'b0);
      drive(1'b1, 16'hC004, 1'b1);
      chk("pt_valid", 32'(trace_valid), 32'd1);
      chk("pt_head",  32'(trace_data),  32'hC001);
      drive(1'b0, '0, 1'b0);
      drain();
      exp_q = '{17'h0C000, 17'h0C001, 17'h0C002, 17'h0C003, 17'h0C004};
      expect_log("pass");

      // coincident sample with overflow-record push keeps the drop run alive
      for (int i = 0; i < 4; i++) drive(1'b1, 16'hD000 + 16'(i), 1'b0);
      drive(1'b1, 16'h5555, 1'b0);
      drive(1'b1, 16'h6666, 1'b0);
      drive(1'b1, 16'h7777, 1'b1);
      drive(1'b0, '0, 1'b0);
      drain();
      exp_q = '{17'h0D000, 17'h0D001, 17'h0D002, 17'h0D003, 17'h10002, 17'h10001};
      expect_log("coin");

      // asynchronous reset mid-operation, with a drop run pending
      for (int i = 0; i < 5; i++) drive(1'b1, 16'hE000 + 16'(i), 1'b0);
      #2 rst_n = 0;
      #1;
      chk("arst_valid", 32'(trace_valid), 32'd0);
      chk("arst_data",  32'(trace_data),  32'd0);
      chk("arst_ovf",   32'(trace_overflow), 32'd0);
      @(posedge clk); #1 rst_n = 1;
      drive(1'b1, 16'hF00D, 1'b0);
      chk("post_rst_push", 32'(trace_data), 32'hF00D);
      drain();
      exp_q = '{17'h0F00D};
      expect_log("postrst");

      // randomized traffic with varying consumer throughput and occasional resets
      thr = 5;
      for (int n = 0; n < 4000; n++) begin
         if (n % 200 == 0) thr = $urandom_range(1, 10);
         drive(1'b1 & ($urandom_range(0, 9) < 7), 16'($urandom), 1'b1 & ($urandom_range(0, 9) < thr));
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 0; #2 rst_n = 1;
         end
      end
      drain();
      chk("final_empty", 32'(trace_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule

// File: doc/osd_trace_sample_buffer.md
OSD_TRACE_SAMPLE_BUFFER -- requirements
Module: osd_trace_sample_buffer

Interface
REQ-001: Parameter WIDTH, default 16, SHALL set the trace sample width in bits; legal range is 10 or more.
REQ-002: Parameter DEPTH, default 4, SHALL set the number of buffer entries; legal values are powers of two, 2 or more.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005: sample_data  input  WIDTH  SHALL carry the trace sample.
REQ-006: sample_valid  input  1  SHALL qualify sample_data for one cycle; there is no backpressure toward the source.
REQ-007: trace_data  output  WIDTH  SHALL carry the head entry payload to the packetizer.
REQ-008: trace_overflow  output  1  SHALL mark the head entry as an overflow record.
REQ-009: trace_valid  output  1  SHALL signal that a head entry is present.
REQ-010: trace_ready  input  1  SHALL be the consumer acceptance of the head entry.

Function
REQ-011: The block SHALL hold a FIFO of DEPTH entries; each entry is {ovf flag, WIDTH-bit payload}.
REQ-012: pop SHALL equal trace_valid AND trace_ready; a pop removes the head entry at the clock edge.
REQ-013: space SHALL be true when occupancy < DEPTH OR pop; a push with a simultaneous pop on a full FIFO is legal.
REQ-014: trace_valid SHALL equal (occupancy != 0), driven from registered state.
REQ-015: When the FIFO is empty, trace_data and trace_overflow SHALL be 0.
REQ-016: The overflow FSM SHALL have two states: NORMAL and PENDING, plus a 10-bit drop counter ovf_cnt.
REQ-017: In NORMAL, sample_valid with space SHALL push {0, sample_data}.
REQ-018: In NORMAL, sample_valid without space SHALL drop the sample, set ovf_cnt to 1, and go to PENDING.
REQ-019: In PENDING, sample_valid without space SHALL drop the sample and increment ovf_cnt, saturating at 1023.
REQ-020: In PENDING with space, the FSM SHALL push {1, zero-extended ovf_cnt} in that cycle; the overflow record takes priority over any sample.
REQ-021: If sample_valid coincides with the overflow-record push, the sample SHALL be dropped, ovf_cnt becomes 1, and the state stays PENDING.
REQ-022: Otherwise, after the overflow-record push, ovf_cnt SHALL become 0 and the state SHALL become NORMAL.
REQ-023: At most one push per cycle is permitted; entry order SHALL be preserved, so the overflow record follows all samples pushed before it.
REQ-024: Latency: an entry pushed in cycle N SHALL be visible with trace_valid=1 in cycle N+1 when the FIFO was empty.
REQ-025: Head payload and flag SHALL stay stable while trace_valid=1 and trace_ready=0.
REQ-026: Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; occupancy SHALL be log2(DEPTH)+1 bits.

Reset
REQ-027: While rst_n=0, the following SHALL hold immediately, independent of clk: occupancy=0, pointers=0, state=NORMAL, ovf_cnt=0, trace_valid=0, trace_data=0, trace_overflow=0.
REQ-028: Storage contents need not be reset.
REQ-029: Reset asserted mid-operation SHALL discard all entries and any pending drop count; no overflow record is emitted for them.
REQ-030: The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=16, DEPTH=4)
REQ-031: Reset behaviour: assert rst_n=0 between clock edges -> trace_valid, trace_data and trace_overflow are 0 without waiting for a clock edge.
REQ-032: In-order delivery: samples 0x1111, 0x2222, 0x3333 on consecutive cycles with trace_ready=1 -> trace_valid rises one cycle after the first sample; data delivered in order; trace_overflow=0 throughout.
REQ-033: Overflow record: trace_ready=0 with 7 consecutive samples, then trace_ready=1 -> the 4 stored samples are delivered, then one entry with trace_overflow=1 and trace_data=0x0003.
REQ-034: Saturation: 1100 samples dropped while full -> the overflow record carries trace_data=0x03FF.
REQ-035: Full-FIFO pass-through: FIFO full in NORMAL, pop and sample_valid in the same cycle -> the sample is accepted, occupancy stays 4, and no overflow record is generated.
REQ-036: Coincident sample: PENDING state, pop coincident with sample_valid -> the overflow record is pushed, ovf_cnt=1, PENDING is retained, and the next record reports 0x0001 (plus any further drops).
